// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/sequencing controller for the 16-bit pipelined processor:
// load-use stalls, EXE-resolved redirects and a multi-cycle data-memory wait state.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              ex_memRead,
  input  logic              ex_wen,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic              ex_branch,
  input  logic              ex_zero,
  input  logic              ex_jump,
  input  logic              ex_jr,
  input  logic              dm_access,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_dm_en,
  output logic              dm_wb_bubble,
  output logic              mem_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [3:0]       MEM_LAT_C = 4'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic [3:0]        wait_cnt_r, wait_cnt_nxt_s;
  logic              served_r, served_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              load_use_s, redirect_s, mem_start_s, flush_inc_s;
  logic [1:0]        pc_sel_dec_s;

  assign load_use_s = ex_memRead & ex_wen & (ex_waddr != {ADDR_W{1'b0}}) &
                      ((ex_waddr == id_rs1) | (id_uses_rs2 & (ex_waddr == id_rs2)));
  assign redirect_s   = (ex_branch & ex_zero) | ex_jump | ex_jr;
  assign pc_sel_dec_s = ex_jr ? 2'd3 : (ex_jump ? 2'd2 : ((ex_branch & ex_zero) ? 2'd1 : 2'd0));
  // A served access is one the wait state already covered; it must not re-trigger.
  assign mem_start_s  = dm_access & ~served_r & (MEM_LAT_C != 4'd0);

  // Next-state and datapath control decode
  always_comb begin
    pc_en          = 1'b1;
    pc_sel         = 2'd0;
    if_id_en       = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_en       = 1'b1;
    id_ex_flush    = 1'b0;
    ex_dm_en       = 1'b1;
    dm_wb_bubble   = 1'b0;
    mem_busy       = 1'b0;
    flush_inc_s    = 1'b0;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    served_nxt_s   = served_r;
    if (!rst) begin
      pc_en          = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      dm_wb_bubble   = 1'b1;
      state_nxt_s    = RUN;
      wait_cnt_nxt_s = 4'd0;
      served_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          served_nxt_s = dm_access & ~mem_start_s;
          if (mem_start_s) begin
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            id_ex_en       = 1'b0;
            ex_dm_en       = 1'b0;
            dm_wb_bubble   = 1'b1;
            mem_busy       = 1'b1;
            state_nxt_s    = WAIT;
            wait_cnt_nxt_s = MEM_LAT_C;
          end else if (redirect_s) begin
            pc_sel      = pc_sel_dec_s;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc_s = 1'b1;
          end else if (load_use_s) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else begin
            pc_en = 1'b1;
          end
        end
        WAIT: begin
          pc_en          = 1'b0;
          if_id_en       = 1'b0;
          id_ex_en       = 1'b0;
          ex_dm_en       = 1'b0;
          dm_wb_bubble   = 1'b1;
          mem_busy       = 1'b1;
          wait_cnt_nxt_s = wait_cnt_r - 4'd1;
          // <= guards against a corrupted zero count locking the pipeline for 16 cycles
          if (wait_cnt_r <= 4'd1) begin
            state_nxt_s    = RUN;
            wait_cnt_nxt_s = 4'd0;
            served_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = WAIT;
          end
        end
        default: begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = 4'd0;
          served_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  // State, wait counter and served-flag registers
  always_ff @(posedge clk) begin
    state_r    <= state_nxt_s;
    wait_cnt_r <= wait_cnt_nxt_s;
    served_r   <= served_nxt_s;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule
